// File: rtl/fetch_pkg.sv
// Shared fetch definitions: opcode constants, B/J immediate decode, queue entry layout.
// No logic of its own, so no latency; consumed by fetch_queue and fetch_unit.
// Defining FETCH_PREDICT_EN adds the predicted-taken bit to every queue entry.
package fetch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
`ifdef FETCH_PREDICT_EN
        logic        pred;
`endif
    } fetch_entry_t;

    // Sign-extended byte offset of a conditional branch.
    function automatic logic [31:0] b_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    // Sign-extended byte offset of a JAL.
    function automatic logic [31:0] j_imm(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundles the instruction-memory port, the execute redirect and the decode handshake.
// Pure wiring, no latency; decode backpressure is carried by id_ready.
// master = fetch_unit side, slave = memory/execute/decode side.
interface fetch_if;

    logic [31:0] i_addr;
    logic [31:0] ins;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic        id_pred_taken;

    modport master (
        output i_addr,
        input  ins,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_ins,
        output id_pc,
        output id_pred_taken
    );

    modport slave (
        input  i_addr,
        output ins,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_ins,
        input  id_pc,
        input  id_pred_taken
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instructions with single-cycle flush.
// Write-to-head latency 1 cycle; head is read straight from the storage registers.
// Push is dropped when full unless a pop happens in the same cycle; flush wins over both.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    output fetch_entry_t head_dat,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign head_dat = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, memory address, next-PC (BTFN when FETCH_PREDICT_EN), fetch queue.
// Fetch-to-decode 1 cycle; redirect-to-target-at-decode 2 cycles; one instruction per cycle sustained.
// Full queue with id_ready low freezes pc/i_addr; redirect flushes the queue and suppresses that cycle's push.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  seq_pc;
    logic [31:0]  next_pc;
    logic         pop;
    logic         fetch_en;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t push_dat;
    fetch_entry_t head_dat;

    assign bus.i_addr = {2'b00, pc_q[31:2]};
    assign seq_pc     = pc_q + 32'd4;

    assign pop      = ~q_empty & bus.id_ready;
    assign fetch_en = ~bus.redirect_valid & (~q_full | pop);

`ifdef FETCH_PREDICT_EN
    logic pred_taken;

    // Backward conditional branches and all JALs are assumed taken.
    always_comb begin
        next_pc    = seq_pc;
        pred_taken = 1'b0;
        if ((bus.ins[6:0] == OPC_BRANCH) && bus.ins[31]) begin
            next_pc    = pc_q + b_imm(bus.ins);
            pred_taken = 1'b1;
        end else if (bus.ins[6:0] == OPC_JAL) begin
            next_pc    = pc_q + j_imm(bus.ins);
            pred_taken = 1'b1;
        end
    end

    assign push_dat          = '{pc: pc_q, ins: bus.ins, pred: pred_taken};
    assign bus.id_pred_taken = head_dat.pred;
`else
    assign next_pc           = seq_pc;
    assign push_dat          = '{pc: pc_q, ins: bus.ins};
    assign bus.id_pred_taken = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc & ~32'h3;
        end else if (fetch_en) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.redirect_valid),
        .push     (fetch_en),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign bus.id_valid = ~q_empty;
    assign bus.id_ins   = head_dat.ins;
    assign bus.id_pc    = head_dat.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected deliveries are queued as stimulus is issued and
// a negedge monitor pops and compares on every id_valid & id_ready handshake.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ = 32'hFE00_0EE3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic beq_en;
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational memory: NOP everywhere, optionally a backward beq at word 2 (pc 8).
    assign bus.ins = (beq_en && (bus.i_addr == 32'd2)) ? BEQ : NOP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_ins(input logic [31:0] pc, input logic [31:0] ins, input logic pred);
        exp_t e;
        e.pc   = pc;
        e.ins  = ins;
        e.pred = pred;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release.
    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.id_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=%h required=no_delivery", bus.id_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", bus.id_pc, e.pc);
                check("sb_ins", bus.id_ins, e.ins);
                check("sb_pred", {31'b0, bus.id_pred_taken}, {31'b0, e.pred});
            end
        end
    end

    initial begin
        rst                = 1'b1;
        beq_en             = 1'b0;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset state
        step();
        step();
        check("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
        check("rst_id_ins", bus.id_ins, 32'h0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_id_pred", {31'b0, bus.id_pred_taken}, 32'd0);
        check("rst_i_addr", bus.i_addr, 32'h0);

        // Streaming with id_ready high: valid one cycle after release, pcs 0,4,8,12
        rst = 1'b0;
        check("empty_no_valid", {31'b0, bus.id_valid}, 32'd0);
        for (int k = 0; k < 4; k++) expect_ins(32'(4 * k), NOP, 1'b0);
        step();
        check("first_valid", {31'b0, bus.id_valid}, 32'd1);
        check("first_pc", bus.id_pc, 32'h0);
        repeat (4) step();
        bus.id_ready = 1'b0;
        check("drain_stream", 32'(exp_q.size()), 32'd0);

        // Stall: queue fills with 4 entries, pc frozen at 16
        do_reset();
        repeat (10) step();
        check("stall_i_addr", bus.i_addr, 32'd4);
        check("stall_id_pc", bus.id_pc, 32'h0);
        check("stall_valid", {31'b0, bus.id_valid}, 32'd1);
        step();
        check("stall_i_addr_hold", bus.i_addr, 32'd4);
        check("stall_id_pc_hold", bus.id_pc, 32'h0);
        // Full queue released: pop and push every cycle
        for (int k = 0; k < 6; k++) expect_ins(32'(4 * k), NOP, 1'b0);
        bus.id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("full_i_addr", bus.i_addr, 32'(4 + k));
            check("full_valid", {31'b0, bus.id_valid}, 32'd1);
            step();
        end
        bus.id_ready = 1'b0;
        check("drain_full", 32'(exp_q.size()), 32'd0);

        // Redirect with 3 entries queued
        do_reset();
        repeat (3) step();
        check("pre_redir_i_addr", bus.i_addr, 32'd3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        step();
        bus.redirect_valid = 1'b0;
        check("redir_n1_valid", {31'b0, bus.id_valid}, 32'd0);
        check("redir_n1_i_addr", bus.i_addr, 32'h40);
        expect_ins(32'h100, NOP, 1'b0);
        expect_ins(32'h104, NOP, 1'b0);
        bus.id_ready = 1'b1;
        step();
        check("redir_n2_valid", {31'b0, bus.id_valid}, 32'd1);
        check("redir_n2_pc", bus.id_pc, 32'h100);
        repeat (2) step();
        bus.id_ready = 1'b0;
        check("drain_redir", 32'(exp_q.size()), 32'd0);

        // Backward beq at pc 8
        beq_en = 1'b1;
        do_reset();
        expect_ins(32'h0, NOP, 1'b0);
        expect_ins(32'h4, NOP, 1'b0);
`ifdef FETCH_PREDICT_EN
        expect_ins(32'h8, BEQ, 1'b1);
        expect_ins(32'h4, NOP, 1'b0);
        expect_ins(32'h8, BEQ, 1'b1);
`else
        expect_ins(32'h8, BEQ, 1'b0);
        expect_ins(32'hC, NOP, 1'b0);
        expect_ins(32'h10, NOP, 1'b0);
`endif
        bus.id_ready = 1'b1;
        repeat (6) step();
        bus.id_ready = 1'b0;
        beq_en       = 1'b0;
        check("drain_beq", 32'(exp_q.size()), 32'd0);

        // Reset overrides a pending redirect with 3 entries queued
        do_reset();
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        rst                = 1'b1;
        step();
        check("mid_rst_valid", {31'b0, bus.id_valid}, 32'd0);
        check("mid_rst_i_addr", bus.i_addr, 32'h0);
        check("mid_rst_id_pc", bus.id_pc, 32'h0);
        check("mid_rst_id_ins", bus.id_ins, 32'h0);
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        check("post_rst_valid", {31'b0, bus.id_valid}, 32'd1);
        check("post_rst_pc", bus.id_pc, 32'h0);

        // PC wrap-around; redirect low bits ignored
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        check("wrap_i_addr_top", bus.i_addr, 32'h3FFF_FFFF);
        expect_ins(32'hFFFF_FFFC, NOP, 1'b0);
        expect_ins(32'h0, NOP, 1'b0);
        bus.id_ready = 1'b1;
        step();
        check("wrap_i_addr_zero", bus.i_addr, 32'h0);
        repeat (2) step();
        bus.id_ready = 1'b0;
        check("drain_wrap", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end sitting directly upstream of the instruction memory. Owns the program counter, drives the memory's word address, captures the combinationally returned instruction word, and buffers fetched instructions in a small queue. The queue feeds decode over a valid/ready handshake. Accepts PC redirects from execute and optionally predicts static branch direction.

## Interface
- `RESET_PC`, 32'h0000_0000: byte PC loaded on reset; bits [1:0] must be 0.
- `QUEUE_DEPTH`, 4: instruction queue entries; power of two, 2..16.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `i_addr`  out  32: word address to instruction memory, `{2'b00, pc[31:2]}`; combinational from the PC register.
- `ins`  in  32: instruction word returned combinationally for `i_addr` in the same cycle.
- `redirect_valid`  in  1: execute requests a fetch restart.
- `redirect_pc`  in  32: byte target of the redirect; bits [1:0] ignored and treated as 0.
- `id_valid`  out  1: queue head holds a valid instruction.
- `id_ready`  in  1: decode accepts the head this cycle.
- `id_ins`  out  32: head instruction word.
- `id_pc`  out  32: byte PC of the head instruction.
- `id_pred_taken`  out  1: head was predicted taken; 0 when prediction is compiled out.

## Operation
- State: `pc` register (32 b), queue of {pc, ins, pred_taken} entries, and an occupancy count (0..QUEUE_DEPTH).
- `pop = id_valid & id_ready`.
- `fetch_en = ~redirect_valid & (count < QUEUE_DEPTH | pop)`. Pop-and-push when full is permitted.
- When `fetch_en` is high, push {pc, ins, pred} at the edge and set `pc <= next_pc`. Otherwise `pc` holds.
- Default `next_pc = pc + 4`, with 32-bit wrap-around (32'hFFFF_FFFC + 4 = 0).
- Redirect has the highest priority. At the edge:
  - The queue is flushed, so count becomes 0.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - No push occurs.
  - A pop in the same cycle is still reported to decode through `id_valid`/`id_ready`, but it is irrelevant because of the flush.
- `id_*` outputs are driven directly from the queue head registers; they are not combinational from `ins`.
- Count update is `count + push − pop`. Read and write pointers wrap modulo QUEUE_DEPTH.
- No address range check: `i_addr` beyond memory size is the memory's concern.

## Timing
- Reset values:
  - `pc = RESET_PC`, count 0, pointers 0.
  - `id_valid = 0`, `id_ins = 0`, `id_pc = 0`, `id_pred_taken = 0`.
  - `i_addr = RESET_PC >> 2`.
- Reset mid-operation discards all queued entries and any pending fetch. `rst` overrides `redirect_valid`.
- Fetch-to-decode latency is 1 cycle: a word fetched in cycle N is at the head (`id_valid = 1`) in cycle N+1 if the queue was empty.
- Redirect penalty: redirect in cycle N → fetch of the target in N+1 → `id_valid` with `id_pc = target` in N+2.
- Throughput is one instruction per cycle when `id_ready` is held high.
- Full queue with `id_ready = 0`: `pc` and `i_addr` are frozen and head outputs are stable.
- Empty queue with `id_ready = 1`: no pop; `id_valid` stays low.

## Configuration
- `FETCH_PREDICT_EN` defined: static BTFN prediction on the fetched `ins`.
  - Opcode 7'b1100011 (B-type) with `ins[31] = 1` (backward): `next_pc = pc + Bimm`, `pred = 1`.
  - Opcode 7'b1101111 (JAL): `next_pc = pc + Jimm`, `pred = 1`.
  - Otherwise `pc + 4`, `pred = 0`.
  - Immediates are sign-extended to 32 b and added with wrap.
- Not defined: `next_pc = pc + 4` always; `id_pred_taken` tied to 0 and the queue stores no pred bit.

## Structure
- Shared package `fetch_pkg` holds:
  - Opcode constants (OPC_BRANCH, OPC_JAL).
  - B-/J-immediate extraction functions.
  - The queue entry struct `fetch_entry_t`.
- Sub-module `fetch_queue` (parameterised synchronous FIFO with flush, push, pop, full/empty).
- `fetch_unit` holds the PC, next-PC logic and the memory interface.

## Test plan
- Reset then `id_ready = 1` with memory words = 32'h00000013 (NOP) → `id_valid` rises 1 cycle after reset release; `id_pc` sequence 0, 4, 8, 12 on consecutive cycles.
- `id_ready = 0` for 10 cycles → exactly 4 pushes. `i_addr` frozen at 4 (pc 16); `id_pc` held at 0. Raising `id_ready` → `id_pc` sequence 0, 4, 8, 12, 16 with no gaps.
- Full queue plus `id_ready = 1` → one pop and one push each cycle; count stays 4.
- `redirect_valid = 1`, `redirect_pc = 32'h0000_0103` in cycle N with 3 entries queued → `id_valid = 0` in N+1; `id_pc = 32'h100` in N+2; no stale entry is delivered.
- With `FETCH_PREDICT_EN`:
  - `ins = 32'hFE000EE3` (beq, −4) at pc 8 → next `id_pc = 4`, `id_pred_taken = 1`.
  - Same word without the macro → `id_pc = 12`, `id_pred_taken = 0`.
- Assert `rst` while 3 entries are queued and a redirect is pending → next cycle `id_valid = 0`, `i_addr = RESET_PC >> 2`.
